mem_arbiter: RTL

// - Shares one single-port synchronous RAM (1-cycle read latency) between instruction fetch (IF, read-only) and data (D, read/write) requesters.
// - Splits unaligned word accesses into two RAM word cycles; merges byte/unaligned writes by read-modify-write. Little-endian byte order.
// - Sits between the CPU pipeline ports and the block RAM. Replaces direct bus access to the RAM.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU-side request/ack ports and RAM-side word port of the memory arbiter.
// slave  = the arbiter's view; master = the CPU pipeline plus block RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 14
) ();
    // instruction fetch port (read-only)
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    // data port (read/write, word or byte)
    logic              d_req;
    logic              d_we;
    logic              d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;

    // single-port synchronous RAM, word addressed
    logic [ADDR_W-3:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_ack, d_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM (1-cycle read latency) between
// instruction fetch (IF) and data (D) requesters. Unaligned word accesses become two RAM
// word cycles; byte and unaligned stores use read-modify-write. Little-endian.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration; otherwise D always
// wins over IF (fixed priority).
// RAM address/write controls are driven combinationally so that a read issued in a state
// returns its data in the very next state.
module mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int WA_W = ADDR_W - 2;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_HI, DONE} state_t;

    state_t              state_q, state_d;
    logic                sel_d_q, sel_d_d;      // latched winner: 1 = D, 0 = IF
    logic                we_q, we_d;
    logic                byte_q, byte_d;
    logic [1:0]          off_q, off_d;
    logic [WA_W-1:0]     wlo_q, wlo_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;            // RAM hi word, or merged hi for stores
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_RR_EN
    logic                last_if_q, last_if_d;  // 1 = IF was granted last
`endif

    logic                grant_d, grant_if;
    logic                req_we, req_byte;
    logic [ADDR_W-1:0]   req_addr;
    logic                unaligned;
    logic [DATA_W-1:0]   rd_word;
    logic [2*DATA_W-1:0] wr_merge;

    // Read result: C[8*off +: 32] for words, zero-extended C[8*off +: 8] for bytes.
    function automatic logic [DATA_W-1:0] merge_read(input logic [2*DATA_W-1:0] c,
                                                     input logic [1:0] off,
                                                     input logic is_byte);
        logic [2*DATA_W-1:0] sh;
        sh = c >> {off, 3'b000};
        return is_byte ? {{(DATA_W-8){1'b0}}, sh[7:0]} : sh[DATA_W-1:0];
    endfunction

    // Store merge: replace C[8*off +: 32] (word) or C[8*off +: 8] (byte) with write data.
    function automatic logic [2*DATA_W-1:0] merge_write(input logic [2*DATA_W-1:0] c,
                                                        input logic [DATA_W-1:0] wd,
                                                        input logic [1:0] off,
                                                        input logic is_byte);
        logic [2*DATA_W-1:0] mask;
        logic [2*DATA_W-1:0] data;
        mask = is_byte ? {{(2*DATA_W-8){1'b0}}, 8'hFF}
                       : {{DATA_W{1'b0}}, {DATA_W{1'b1}}};
        mask = mask << {off, 3'b000};
        data = {{DATA_W{1'b0}}, wd} << {off, 3'b000};
        return (c & ~mask) | (data & mask);
    endfunction

    // Arbitration: D over IF, or alternate on a tie when round-robin is enabled.
    always_comb begin
        grant_d = bus.d_req;
`ifdef MEM_ARB_RR_EN
        if (bus.d_req && bus.if_req) begin
            grant_d = last_if_q;
        end
`endif
        grant_if = bus.if_req && !grant_d;
        req_we   = grant_d ? bus.d_we   : 1'b0;
        req_byte = grant_d ? bus.d_size : 1'b0;
        req_addr = grant_d ? bus.d_addr : bus.if_addr;
    end

    // Next-state, request latching, RAM controls and registered acknowledges.
    always_comb begin
        // NOTE: every signal gets a default before the case; a missed branch would otherwise infer a latch.
        state_d       = state_q;
        sel_d_d       = sel_d_q;
        we_d          = we_q;
        byte_d        = byte_q;
        off_d         = off_q;
        wlo_d         = wlo_q;
        wdata_d       = wdata_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        if_ack_d      = 1'b0;
        d_ack_d       = 1'b0;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_if_d     = last_if_q;
`endif
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        unaligned     = !byte_q && (off_q != 2'd0);
        rd_word       = '0;
        wr_merge      = '0;

        case (state_q)
            IDLE: begin
                if (grant_d || grant_if) begin
                    sel_d_d = grant_d;
                    we_d    = req_we;
                    byte_d  = req_byte;
                    off_d   = req_addr[1:0];
                    wlo_d   = req_addr[ADDR_W-1:2];
                    wdata_d = bus.d_wdata;
`ifdef MEM_ARB_RR_EN
                    last_if_d = grant_if;
`endif
                    bus.ram_addr = req_addr[ADDR_W-1:2];
                    if (req_we && !req_byte && (req_addr[1:0] == 2'd0)) begin
                        bus.ram_we    = 1'b1;
                        bus.ram_wdata = bus.d_wdata;
                        d_ack_d       = grant_d;
                        if_ack_d      = !grant_d;
                        state_d       = DONE;
                    end else begin
                        state_d = RD_LO;
                    end
                end
            end

            RD_LO: begin
                lo_d     = bus.ram_rdata;
                rd_word  = merge_read({hi_q, bus.ram_rdata}, off_q, byte_q);
                wr_merge = merge_write({hi_q, bus.ram_rdata}, wdata_q, off_q, byte_q);
                if (!we_q && !unaligned) begin
                    d_ack_d    = sel_d_q;
                    if_ack_d   = !sel_d_q;
                    if (sel_d_q) d_rdata_d = rd_word;
                    else         if_rdata_d = rd_word;
                    state_d    = IDLE;
                end else if (we_q && byte_q) begin
                    bus.ram_we    = 1'b1;
                    bus.ram_addr  = wlo_q;
                    bus.ram_wdata = wr_merge[DATA_W-1:0];
                    d_ack_d       = sel_d_q;
                    if_ack_d      = !sel_d_q;
                    state_d       = DONE;
                end else begin
                    bus.ram_addr = wlo_q + WA_W'(1);
                    state_d      = RD_HI;
                end
            end

            RD_HI: begin
                hi_d     = bus.ram_rdata;
                rd_word  = merge_read({bus.ram_rdata, lo_q}, off_q, byte_q);
                wr_merge = merge_write({bus.ram_rdata, lo_q}, wdata_q, off_q, byte_q);
                if (!we_q) begin
                    d_ack_d  = sel_d_q;
                    if_ack_d = !sel_d_q;
                    if (sel_d_q) d_rdata_d = rd_word;
                    else         if_rdata_d = rd_word;
                    state_d  = IDLE;
                end else begin
                    bus.ram_we    = 1'b1;
                    bus.ram_addr  = wlo_q;
                    bus.ram_wdata = wr_merge[DATA_W-1:0];
                    hi_d          = wr_merge[2*DATA_W-1:DATA_W];
                    state_d       = WR_HI;
                end
            end

            WR_HI: begin
                bus.ram_we    = 1'b1;
                bus.ram_addr  = wlo_q + WA_W'(1);
                bus.ram_wdata = hi_q;
                d_ack_d       = sel_d_q;
                if_ack_d      = !sel_d_q;
                state_d       = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset aborts the access at once; the RAM must not see a write while it is held.
        if (rst) begin
            bus.ram_we    = 1'b0;
            bus.ram_addr  = '0;
            bus.ram_wdata = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_d_q    <= 1'b0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            off_q      <= 2'd0;
            wlo_q      <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last_if_q  <= 1'b1;   // favour D on the first tie
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            sel_d_q    <= sel_d_d;
            we_q       <= we_d;
            byte_q     <= byte_d;
            off_q      <= off_d;
            wlo_q      <= wlo_d;
            wdata_q    <= wdata_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_if_q  <= last_if_d;
`endif
        end
    end

    assign bus.if_ack   = if_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.busy     = (state_q != IDLE);

endmodule
